pcie_tx_mux: RTL
================

Name: pcie_tx_mux

Overview:
- Parametrised PCIe transmit TLP framer and arbiter between the request/completion sources and the PCIe core's 64-bit AXI-stream TX interface.
- Serialises three TLP kinds:
  - 2-DW read completions (CplD).
  - Memory read requests (MRd).
  - Memory write requests (MWr) with a configurable payload.
- Selects 3-DW or 4-DW headers from the address, realigning write payload in 3-DW mode.
- Uses a proper valid/ready output register and round-robin fairness between reads and writes.

Parameters:
- WR_PAYLOAD_DW, 32: MWr payload length in DW. Must be even, 2..256.
- RD_REQ_DW, 128: MRd length field in DW, 1..1024. A value of 1024 is encoded as 0.
- ADDR64_ONLY, 0: 1 forces 4-DW headers for every request.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- pcie_id, in, 16: requester/completer ID.
- read_completion_valid, in, 1: completion pending.
- read_completion_rid_tag, in, 24: requester ID and tag.
- read_completion_lower_addr, in, 4: lower address bits [6:3].
- read_completion_data, in, 64: completion data, little-endian.
- read_completion_ready, out, 1: one-cycle pulse when the completion's last beat is accepted.
- read_request_valid, in, 1: read request pending.
- read_request_address, in, 64: read address.
- read_request_tag, in, 8: read tag.
- read_request_ready, out, 1: one-cycle pulse on last-beat acceptance.
- write_request_valid, in, 1: full payload available; address is stable.
- write_request_address, in, 64: write address.
- write_request_data, in, 64: current payload word.
- write_data_ready, out, 1: pulse per payload word consumed; the source advances next cycle.
- write_request_done, out, 1: pulse on MWr last-beat acceptance.
- axis_tx_tready, in, 1: core ready.
- axis_tx_tdata, out, 64: beat data.
- axis_tx_1dw, out, 1: only tdata[31:0] is valid (last beat only).
- axis_tx_tlast, out, 1: last beat of the TLP.
- axis_tx_tvalid, out, 1: beat valid.

Behaviour:
- **Reset:** asynchronous. All outputs are 0, the FSM is IDLE and the round-robin pointer selects reads.
- **Output stage:** a single output register.
  - A beat is transferred when tvalid && tready.
  - While tvalid && !tready, tdata, tlast and 1dw hold stable.
  - The next beat loads in the same cycle as the transfer, so back-to-back beats run with no bubble.
- **Arbitration in IDLE:**
  - A completion has absolute priority.
  - Otherwise MRd vs MWr is round-robin; the pointer flips to the other class after a TLP of either class is granted.
  - Grant decisions are made only in IDLE. The selected inputs are sampled into header registers at grant; write data is not sampled at grant.
  - The cycle after a TLP's last beat is accepted, the FSM may grant again. One idle cycle between TLPs is allowed.
- **Header select:** 4-DW when ADDR64_ONLY, or when address[63:32] != 0; otherwise 3-DW.
- **Header fields:**
  - CplD: dw0=4A000002, dw1={pcie_id,16'd8}, dw2={rid_tag,1'b0,lower_addr,3'b0}.
  - MRd: fmt 000 (3-DW) or 001 (4-DW); length=RD_REQ_DW[9:0]; dw1={pcie_id,tag,8'hFF}.
  - MWr: fmt 010 (3-DW) or 011 (4-DW); length=WR_PAYLOAD_DW[9:0]; dw1={pcie_id,8'h00,8'hFF}.
  - Every payload DW is byte-swapped (endian swap per 32-bit word).
- **Beat maps** (tdata = {upper DW, lower DW}):
  - CplD: {dw1,dw0}, {d0,dw2}, {0,d1} with 1dw. 3 beats.
  - MRd 4-DW: {dw1,dw0}, {addrLo,addrHi}. 2 beats.
  - MRd 3-DW: {dw1,dw0}, {0,addrLo} with 1dw. 2 beats.
  - MWr 4-DW: {dw1,dw0}, {addrLo,addrHi}, then WR_PAYLOAD_DW/2 beats {d(2k+1),d(2k)}.
  - MWr 3-DW: {dw1,dw0}, {d0,addrLo}, {d2,d1}, ..., and a final {0,d(N-1)} with 1dw. Total 2+N/2 beats.
  - The 3-DW payload is realigned via a held register for the upper DW of the previous word.
- **Write data consumption:**
  - write_data_ready pulses exactly WR_PAYLOAD_DW/2 times per MWr, each when its word is loaded into the output register.
  - write_request_done pulses on last-beat acceptance.
- **Beat counter:** 8 bits, counts accepted payload beats, compared to WR_PAYLOAD_DW/2-1 for tlast. No wrap within a TLP.
- **Source changes after grant:** deassertion of a source's valid after grant does not abort the TLP. The latched header completes.
- **Reset mid-TLP:** the TLP is truncated and tvalid drops immediately. No done or ready pulse is issued.

Test Plan:
- Completion only, tready=1, data=0x1122334455667788, lower_addr=5 -> exactly 3 beats:
  - beat1 lower DW=00000028 | rid_tag<<8.
  - beat1 upper DW=0x88776655.
  - beat2 1dw=1, tdata[31:0]=0x44332211.
  - tlast on beat2; read_completion_ready pulses once.
- MRd at 0x0000_0001_0000_1000, tag 7 -> 2 beats; dw0=20000080, beat1={00001000,00000001}, no 1dw. Repeat at 0x1000 -> dw0=00000080, beat1 1dw=1.
- MWr with WR_PAYLOAD_DW=4, address 0x2000 (3-DW), data words W0,W1 -> 4 beats: {dw1,40000004}, {swap(W0lo),00002000}, {swap(W1lo),swap(W0hi)}, {0,swap(W1hi)} with 1dw+tlast. write_data_ready pulses 2 times.
- Read and write requests both held valid -> MRd, MWr, MRd, MWr grant order. A completion asserted mid-MWr is granted next, before the pending MRd.
- tready toggling 1010... during a 4-DW MWr -> every beat is held stable while stalled, no beat is lost or duplicated, and the payload matches the serial reference.
- reset asserted on MWr beat 2 -> tvalid=0 at once, FSM IDLE, no write_request_done; the next MWr frames correctly from beat 0.

Source files
------------

// File: rtl/pcie_tx_mux.sv
// PCIe TX TLP framer: serialises CplD, MRd and MWr TLPs onto a 64-bit AXI-stream port.
// Completions take priority; reads and writes share the port round-robin.
module pcie_tx_mux #(
    parameter int unsigned WR_PAYLOAD_DW = 32,
    parameter int unsigned RD_REQ_DW     = 128,
    parameter bit          ADDR64_ONLY   = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pcie_id,
    input  logic        read_completion_valid,
    input  logic [23:0] read_completion_rid_tag,
    input  logic [3:0]  read_completion_lower_addr,
    input  logic [63:0] read_completion_data,
    output logic        read_completion_ready,
    input  logic        read_request_valid,
    input  logic [63:0] read_request_address,
    input  logic [7:0]  read_request_tag,
    output logic        read_request_ready,
    input  logic        write_request_valid,
    input  logic [63:0] write_request_address,
    input  logic [63:0] write_request_data,
    output logic        write_data_ready,
    output logic        write_request_done,
    input  logic        axis_tx_tready,
    output logic [63:0] axis_tx_tdata,
    output logic        axis_tx_1dw,
    output logic        axis_tx_tlast,
    output logic        axis_tx_tvalid
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;
    localparam logic [2:0] ST_LAST = 3'd5;

    localparam logic [1:0] K_CPL = 2'd0;
    localparam logic [1:0] K_MRD = 2'd1;
    localparam logic [1:0] K_MWR = 2'd2;

    localparam logic [9:0] WR_LEN   = WR_PAYLOAD_DW[9:0];
    localparam logic [9:0] RD_LEN   = RD_REQ_DW[9:0];
    localparam logic [7:0] LAST_CNT = 8'(WR_PAYLOAD_DW / 2 - 1);
    localparam bit         ONE_WORD = (WR_PAYLOAD_DW == 2);

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [2:0]  state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic        hdr4_q, hdr4_d;
    logic        rr_q, rr_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  tag_q, tag_d;
    logic [23:0] rid_tag_q, rid_tag_d;
    logic [3:0]  low_addr_q, low_addr_d;
    logic [63:0] cpl_data_q, cpl_data_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        t1dw_q, t1dw_d;
    logic        tvalid_q, tvalid_d;

    logic        load_en, accept, last_acc, wdr;
    logic [31:0] dw0, dw1;

    always_comb begin
        unique case (kind_q)
            K_CPL: begin
                dw0 = 32'h4A00_0002;
                dw1 = {pcie_id, 16'd8};
            end
            K_MRD: begin
                dw0 = {2'b00, hdr4_q, 19'd0, RD_LEN};
                dw1 = {pcie_id, tag_q, 8'hFF};
            end
            default: begin
                dw0 = {2'b01, hdr4_q, 19'd0, WR_LEN};
                dw1 = {pcie_id, 8'h00, 8'hFF};
            end
        endcase
    end

    always_comb begin
        load_en    = !tvalid_q || axis_tx_tready;
        accept     = tvalid_q && axis_tx_tready;
        state_d    = state_q;
        kind_d     = kind_q;
        hdr4_d     = hdr4_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        rid_tag_d  = rid_tag_q;
        low_addr_d = low_addr_q;
        cpl_data_d = cpl_data_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        t1dw_d     = t1dw_q;
        tvalid_d   = tvalid_q && !axis_tx_tready;
        wdr        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (read_completion_valid) begin
                    kind_d     = K_CPL;
                    hdr4_d     = 1'b0;
                    rid_tag_d  = read_completion_rid_tag;
                    low_addr_d = read_completion_lower_addr;
                    cpl_data_d = read_completion_data;
                    state_d    = ST_HDR0;
                end else if (read_request_valid && (!write_request_valid || !rr_q)) begin
                    kind_d  = K_MRD;
                    hdr4_d  = ADDR64_ONLY || (read_request_address[63:32] != 32'd0);
                    addr_d  = read_request_address;
                    tag_d   = read_request_tag;
                    rr_d    = 1'b1;
                    state_d = ST_HDR0;
                end else if (write_request_valid) begin
                    kind_d  = K_MWR;
                    hdr4_d  = ADDR64_ONLY || (write_request_address[63:32] != 32'd0);
                    addr_d  = write_request_address;
                    rr_d    = 1'b0;
                    state_d = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (load_en) begin
                    tdata_d  = {dw1, dw0};
                    tlast_d  = 1'b0;
                    t1dw_d   = 1'b0;
                    tvalid_d = 1'b1;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (load_en) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    t1dw_d   = 1'b0;
                    if (kind_q == K_CPL) begin
                        tdata_d = {bswap(cpl_data_q[31:0]), rid_tag_q, 1'b0, low_addr_q, 3'b000};
                        hold_d  = bswap(cpl_data_q[63:32]);
                        state_d = ST_TAIL;
                    end else if (hdr4_q) begin
                        tdata_d = {addr_q[31:0], addr_q[63:32]};
                        tlast_d = (kind_q == K_MRD);
                        cnt_d   = 8'd0;
                        state_d = (kind_q == K_MRD) ? ST_LAST : ST_PAY;
                    end else if (kind_q == K_MRD) begin
                        tdata_d = {32'd0, addr_q[31:0]};
                        tlast_d = 1'b1;
                        t1dw_d  = 1'b1;
                        state_d = ST_LAST;
                    end else begin
                        // 3-DW write: payload slips by one DW, upper half waits in hold_q
                        tdata_d = {bswap(write_request_data[31:0]), addr_q[31:0]};
                        hold_d  = bswap(write_request_data[63:32]);
                        wdr     = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = ONE_WORD ? ST_TAIL : ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (load_en) begin
                    tvalid_d = 1'b1;
                    t1dw_d   = 1'b0;
                    wdr      = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                    if (hdr4_q) begin
                        tdata_d = {bswap(write_request_data[63:32]), bswap(write_request_data[31:0])};
                        tlast_d = (cnt_q == LAST_CNT);
                        state_d = (cnt_q == LAST_CNT) ? ST_LAST : ST_PAY;
                    end else begin
                        tdata_d = {bswap(write_request_data[31:0]), hold_q};
                        hold_d  = bswap(write_request_data[63:32]);
                        tlast_d = 1'b0;
                        state_d = (cnt_q == LAST_CNT) ? ST_TAIL : ST_PAY;
                    end
                end
            end
            ST_TAIL: begin
                if (load_en) begin
                    tdata_d  = {32'd0, hold_q};
                    tlast_d  = 1'b1;
                    t1dw_d   = 1'b1;
                    tvalid_d = 1'b1;
                    state_d  = ST_LAST;
                end
            end
            ST_LAST: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign last_acc              = (state_q == ST_LAST) && accept;
    assign read_completion_ready = last_acc && (kind_q == K_CPL);
    assign read_request_ready    = last_acc && (kind_q == K_MRD);
    assign write_request_done    = last_acc && (kind_q == K_MWR);
    assign write_data_ready      = wdr;
    assign axis_tx_tdata         = tdata_q;
    assign axis_tx_tlast         = tlast_q;
    assign axis_tx_1dw           = t1dw_q;
    assign axis_tx_tvalid        = tvalid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= K_CPL;
            hdr4_q     <= 1'b0;
            rr_q       <= 1'b0;
            addr_q     <= 64'd0;
            tag_q      <= 8'd0;
            rid_tag_q  <= 24'd0;
            low_addr_q <= 4'd0;
            cpl_data_q <= 64'd0;
            hold_q     <= 32'd0;
            cnt_q      <= 8'd0;
            tdata_q    <= 64'd0;
            tlast_q    <= 1'b0;
            t1dw_q     <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            hdr4_q     <= hdr4_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            rid_tag_q  <= rid_tag_d;
            low_addr_q <= low_addr_d;
            cpl_data_q <= cpl_data_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            t1dw_q     <= t1dw_d;
            tvalid_q   <= tvalid_d;
        end
    end

endmodule
